ins_fetch: RTL

Instruction fetch and sequencing unit that drives the 20-bit `ins` input of `cpum` and consumes its `zf`/`sf` flag outputs. It holds a loadable 256-word program store, a program counter and a small run-control state machine. It resolves control-flow opcodes locally (jumps, conditional branches, halt) and issues every other word to the CPU, one instruction per clock.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/prog_mem.sv | 17 +
 rtl/ins_fetch.sv | 87 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, no-op word and run-control states shared by the fetch unit
package cpu_pkg;
  localparam logic [3:0] OP_RET  = 4'hA;
  localparam logic [3:0] OP_CALL = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_JS   = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;
  localparam logic [19:0] NOP = 20'h00000;
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
endpackage

// File: rtl/prog_mem.sv
// prog_mem: program store, one registered write port, asynchronous read
module prog_mem #(
  parameter int AW = 8,
  parameter int IW = 20
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);
  logic [IW-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/ins_fetch.sv
// ins_fetch: instruction fetch/sequencing unit feeding cpum
// Optional CALL/RET with a one-deep link register: define INS_FETCH_CALL_EN
module ins_fetch
  import cpu_pkg::*;
#(
  parameter int AW = 8,
  parameter int IW = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic          zf,
  input  logic          sf,
  output logic [IW-1:0] ins,
  output logic [AW-1:0] pc,
  output logic          running,
  output logic          halted
);
  state_t state;
  logic [IW-1:0] w;
  logic [3:0] op;
  logic [AW-1:0] tgt, inc, pc_nxt;
  logic ctl, jump;
`ifdef INS_FETCH_CALL_EN
  logic [AW-1:0] link;
`endif
  prog_mem #(.AW(AW), .IW(IW)) u_mem (
    .clk  (clk),
    .we   (load_en && state != RUN),
    .waddr(load_addr),
    .wdata(load_data),
    .raddr(pc),
    .rdata(w)
  );
  assign op  = w[IW-1:IW-4];
  assign tgt = w[AW-1:0];
  assign inc = pc + AW'(1);
  // control opcodes occupy the top of the opcode space
  always_comb begin
`ifdef INS_FETCH_CALL_EN
    ctl    = op >= OP_RET;
    jump   = op == OP_JMP || op == OP_CALL || (op == OP_JZ && zf) || (op == OP_JS && sf);
    pc_nxt = op == OP_RET ? link : jump ? tgt : op == OP_HLT ? pc : inc;
`else
    ctl    = op >= OP_JMP;
    jump   = op == OP_JMP || (op == OP_JZ && zf) || (op == OP_JS && sf);
    pc_nxt = jump ? tgt : op == OP_HLT ? pc : inc;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= '0;
      ins     <= NOP;
      running <= 1'b0;
      halted  <= 1'b0;
`ifdef INS_FETCH_CALL_EN
      link    <= '0;
`endif
    end else if (stop) begin
      state   <= IDLE;
      ins     <= NOP;
      running <= 1'b0;
      halted  <= 1'b0;
    end else if (state == RUN) begin
      ins <= ctl ? NOP : w;
      pc  <= pc_nxt;
      if (op == OP_HLT) begin
        state   <= HALT;
        running <= 1'b0;
        halted  <= 1'b1;
      end
`ifdef INS_FETCH_CALL_EN
      if (op == OP_CALL) link <= inc;
`endif
    end else if (start) begin
      state   <= RUN;
      pc      <= '0;
      ins     <= NOP;
      running <= 1'b1;
      halted  <= 1'b0;
    end
endmodule
